// File: rtl/utim64_pkg.sv
// Shared definitions for the utim64 compare channel: width default,
// channel state encoding and mode encoding.
package utim64_pkg;

  localparam int UTIM64_P_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } comp_state_t;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } comp_mode_t;

endpackage

// File: rtl/utim64_comp_reg.sv
// Compare register with per-half write mask plus the period register and
// the modular adder that advances the compare value in periodic mode.
module utim64_comp_reg #(
  parameter int P_WIDTH = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_write,
  input  logic [1:0]         in_dqm,
  input  logic [P_WIDTH-1:0] i_wdata,
  input  logic               i_period_write,
  input  logic [P_WIDTH-1:0] i_period,
  input  logic               i_advance,
  output logic [P_WIDTH-1:0] o_value,
  output logic               o_period_zero
);

  localparam int HALF = P_WIDTH / 2;

  logic [P_WIDTH-1:0] r_value;
  logic [P_WIDTH-1:0] r_period;

  // Advance and write never coincide: writes are only taken while not armed,
  // and advances only happen on an armed match.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_value  <= '0;
      r_period <= '0;
    end else begin
      if (i_advance) begin
        r_value <= r_value + r_period;
      end else if (i_write) begin
        if (!in_dqm[0]) r_value[HALF-1:0]       <= i_wdata[HALF-1:0];
        if (!in_dqm[1]) r_value[P_WIDTH-1:HALF] <= i_wdata[P_WIDTH-1:HALF];
      end
      if (i_period_write) r_period <= i_period;
    end
  end

  assign o_value       = r_value;
  assign o_period_zero = (r_period == '0);

endmodule

// File: rtl/utim64_comparator.sv
// One compare channel of the utim64 timer: matches the main counter against
// a compare value and raises a level interrupt until acknowledged.
module utim64_comparator
  import utim64_pkg::*;
#(
  parameter int P_WIDTH = UTIM64_P_WIDTH
) (
  input  logic               iCLOCK,
  input  logic               iRESET,
  input  logic               iCONF_WRITE,
  input  logic               iCONF_ENA,
  input  logic               iCONF_MODE,
  input  logic               iCOMP_WRITE,
  input  logic [1:0]         inCOMP_DQM,
  input  logic [P_WIDTH-1:0] iCOMP_VALUE,
  input  logic               iPERIOD_WRITE,
  input  logic [P_WIDTH-1:0] iPERIOD,
  input  logic               iMAIN_WORKING,
  input  logic [P_WIDTH-1:0] iMAIN_COUNTER,
  input  logic               iIRQ_ACK,
  output logic               oIRQ,
  output logic               oMISSED,
  output logic               oENABLED,
  output logic [P_WIDTH-1:0] oCOMP_VALUE
);

  comp_state_t        r_state;
  comp_mode_t         r_mode;
  logic               r_irq;
  logic               r_missed;
  logic [P_WIDTH-1:0] w_comp;
  logic               w_period_zero;
  logic               w_match;
  logic               w_advance;
  logic               w_comp_write;

  assign w_match      = (r_state == ST_ARMED) && iMAIN_WORKING && (iMAIN_COUNTER == w_comp);
  assign w_advance    = w_match && (r_mode == MODE_PERIODIC) && !w_period_zero;
  assign w_comp_write = iCOMP_WRITE && (r_state != ST_ARMED);

  utim64_comp_reg #(
    .P_WIDTH(P_WIDTH)
  ) u_comp_reg (
    .i_clk         (iCLOCK),
    .i_rst         (iRESET),
    .i_write       (w_comp_write),
    .in_dqm        (inCOMP_DQM),
    .i_wdata       (iCOMP_VALUE),
    .i_period_write(iPERIOD_WRITE),
    .i_period      (iPERIOD),
    .i_advance     (w_advance),
    .o_value       (w_comp),
    .o_period_zero (w_period_zero)
  );

  // Match uses pre-write state and mode; a config write in the same cycle
  // is applied last so it overrides the match's state (and disable its IRQ).
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_ONESHOT;
      r_irq    <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      if (w_match) begin
        r_irq    <= 1'b1;
        r_missed <= !iIRQ_ACK && (r_missed || r_irq);
        if (!w_advance) r_state <= ST_DONE;
      end else if (iIRQ_ACK) begin
        r_irq    <= 1'b0;
        r_missed <= 1'b0;
      end
      if (iCONF_WRITE) begin
        r_mode <= comp_mode_t'(iCONF_MODE);
        if (iCONF_ENA) begin
          r_state <= ST_ARMED;
        end else begin
          r_state  <= ST_IDLE;
          r_irq    <= 1'b0;
          r_missed <= 1'b0;
        end
      end
    end
  end

  assign oIRQ        = r_irq;
  assign oMISSED     = r_missed;
  assign oENABLED    = (r_state != ST_IDLE);
  assign oCOMP_VALUE = w_comp;

endmodule

// File: tb/tb_utim64_comparator.sv
// Self-checking bench for utim64_comparator: directed scenarios plus a
// randomized phase, all checked against a behavioural channel model.
module tb_utim64_comparator;

  logic        clk;
  logic        rst;
  logic        conf_write;
  logic        conf_ena;
  logic        conf_mode;
  logic        comp_write;
  logic [1:0]  comp_dqm;
  logic [63:0] comp_value;
  logic        period_write;
  logic [63:0] period;
  logic        working;
  logic [63:0] counter;
  logic        ack;
  logic        irq;
  logic        missed;
  logic        enabled;
  logic [63:0] comp_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Behavioural model of the channel
  bit          m_en;
  bit          m_fired;
  bit          m_periodic;
  bit          m_irq;
  bit          m_missed;
  logic [63:0] m_comp;
  logic [63:0] m_period;

  utim64_comparator #(
    .P_WIDTH(64)
  ) dut (
    .iCLOCK       (clk),
    .iRESET       (rst),
    .iCONF_WRITE  (conf_write),
    .iCONF_ENA    (conf_ena),
    .iCONF_MODE   (conf_mode),
    .iCOMP_WRITE  (comp_write),
    .inCOMP_DQM   (comp_dqm),
    .iCOMP_VALUE  (comp_value),
    .iPERIOD_WRITE(period_write),
    .iPERIOD      (period),
    .iMAIN_WORKING(working),
    .iMAIN_COUNTER(counter),
    .iIRQ_ACK     (ack),
    .oIRQ         (irq),
    .oMISSED      (missed),
    .oENABLED     (enabled),
    .oCOMP_VALUE  (comp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_fired = 0; m_periodic = 0; m_irq = 0; m_missed = 0;
    m_comp = '0; m_period = '0;
  endtask

  task automatic model_step();
    bit          armed;
    bit          hit;
    logic [63:0] nxt;
    armed = m_en && !m_fired;
    hit   = armed && working && (counter == m_comp);
    nxt   = m_comp;
    if (comp_write && !armed) begin
      if (!comp_dqm[0]) nxt = {nxt[63:32], comp_value[31:0]};
      if (!comp_dqm[1]) nxt = {comp_value[63:32], nxt[31:0]};
    end
    if (hit && m_periodic && m_period != 0) nxt = m_comp + m_period;
    else if (hit) m_fired = 1;
    if (hit) begin
      m_missed = ack ? 1'b0 : (m_missed | m_irq);
      m_irq    = 1;
    end else if (ack) begin
      m_irq = 0; m_missed = 0;
    end
    m_comp = nxt;
    if (period_write) m_period = period;
    if (conf_write) begin
      m_periodic = conf_mode;
      m_en       = conf_ena;
      m_fired    = 0;
      if (!conf_ena) begin
        m_irq = 0; m_missed = 0;
      end
    end
  endtask

  task automatic check_model();
    check("irq", {63'd0, irq}, {63'd0, m_irq});
    check("missed", {63'd0, missed}, {63'd0, m_missed});
    check("enabled", {63'd0, enabled}, {63'd0, m_en});
    check("comp", comp_out, m_comp);
  endtask

  task automatic clr();
    conf_write = 0; comp_write = 0; period_write = 0; ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic conf(input bit ena, input bit mode);
    conf_write = 1; conf_ena = ena; conf_mode = mode;
    tick(); clr();
  endtask

  task automatic comp_wr(input logic [1:0] dqm, input logic [63:0] v);
    comp_write = 1; comp_dqm = dqm; comp_value = v;
    tick(); clr();
  endtask

  task automatic period_wr(input logic [63:0] p);
    period_write = 1; period = p;
    tick(); clr();
  endtask

  task automatic cnt(input logic [63:0] v);
    counter = v;
    tick();
  endtask

  task automatic ack_pulse();
    ack = 1;
    tick(); clr();
  endtask

  initial begin
    clr();
    conf_ena = 0; conf_mode = 0; comp_dqm = 2'b00; comp_value = '0;
    period = '0; working = 0; counter = '0;
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_irq", {63'd0, irq}, 64'd0);
    check("rst_enabled", {63'd0, enabled}, 64'd0);
    check("rst_comp", comp_out, 64'd0);

    // One-shot
    comp_wr(2'b00, 64'h10);
    conf(1, 0);
    check("os_enabled", {63'd0, enabled}, 64'd1);
    working = 1;
    for (int v = 14; v <= 18; v++) begin
      cnt(64'(v));
      check("os_irq", {63'd0, irq}, (v >= 16) ? 64'd1 : 64'd0);
    end
    cnt(64'h10);
    check("os_no_second", {63'd0, missed}, 64'd0);
    ack_pulse();
    check("os_ack", {63'd0, irq}, 64'd0);

    // Periodic
    working = 0;
    conf(0, 0);
    period_wr(64'h40);
    comp_wr(2'b00, 64'h100);
    conf(1, 1);
    working = 1;
    cnt(64'hFF);
    check("per_pre", {63'd0, irq}, 64'd0);
    cnt(64'h100);
    check("per_irq1", {63'd0, irq}, 64'd1);
    check("per_comp1", comp_out, 64'h140);
    cnt(64'h120);
    cnt(64'h140);
    check("per_missed", {63'd0, missed}, 64'd1);
    check("per_comp2", comp_out, 64'h180);
    working = 0;
    ack_pulse();
    check("per_ack_irq", {63'd0, irq}, 64'd0);
    check("per_ack_missed", {63'd0, missed}, 64'd0);

    // Wrap-around advance
    conf(0, 0);
    period_wr(64'h20);
    comp_wr(2'b00, 64'hFFFF_FFFF_FFFF_FFF0);
    conf(1, 1);
    working = 1;
    cnt(64'hFFFF_FFFF_FFFF_FFF0);
    check("wrap_comp", comp_out, 64'h10);
    ack_pulse();
    cnt(64'h10);
    check("wrap_irq", {63'd0, irq}, 64'd1);
    check("wrap_comp2", comp_out, 64'h30);

    // DQM writes
    working = 0;
    conf(0, 0);
    comp_wr(2'b00, 64'h0);
    comp_wr(2'b10, 64'hAAAA_BBBB_CCCC_DDDD);
    check("dqm_low", comp_out, 64'h0000_0000_CCCC_DDDD);
    conf(1, 0);
    comp_wr(2'b00, 64'hAAAA_BBBB_CCCC_DDDD);
    check("dqm_armed", comp_out, 64'h0000_0000_CCCC_DDDD);

    // Ack and match together, then disable and match together
    conf(0, 0);
    period_wr(64'h10);
    comp_wr(2'b00, 64'h200);
    conf(1, 1);
    working = 1;
    cnt(64'h200);
    check("sim_irq", {63'd0, irq}, 64'd1);
    ack = 1;
    cnt(64'h210);
    clr();
    check("ackmatch_irq", {63'd0, irq}, 64'd1);
    check("ackmatch_missed", {63'd0, missed}, 64'd0);
    conf_write = 1; conf_ena = 0; conf_mode = 1;
    cnt(64'h220);
    clr();
    check("dismatch_irq", {63'd0, irq}, 64'd0);
    check("dismatch_en", {63'd0, enabled}, 64'd0);

    // Stopped counter and skipped-over compare value
    working = 0;
    comp_wr(2'b00, 64'h500);
    conf(1, 0);
    cnt(64'h500);
    check("stopped", {63'd0, irq}, 64'd0);
    working = 1;
    cnt(64'h4FF);
    cnt(64'h501);
    check("skip", {63'd0, irq}, 64'd0);
    cnt(64'h500);
    check("pre_rst_irq", {63'd0, irq}, 64'd1);

    // Asynchronous reset between clock edges
    #2 rst = 1;
    #1;
    check("arst_irq", {63'd0, irq}, 64'd0);
    check("arst_missed", {63'd0, missed}, 64'd0);
    check("arst_enabled", {63'd0, enabled}, 64'd0);
    check("arst_comp", comp_out, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 0;

    // Randomized phase
    counter = '0;
    for (int i = 0; i < 600; i++) begin
      clr();
      working = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) counter = m_comp - 64'($urandom_range(0, 3));
      else if (working) counter = counter + 64'd1;
      if ($urandom_range(0, 11) == 0) begin
        conf_write = 1;
        conf_ena   = ($urandom_range(0, 3) != 0);
        conf_mode  = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 5) == 0) begin
        comp_write = 1;
        comp_dqm   = 2'($urandom_range(0, 3));
        comp_value = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 7) == 0) begin
        period_write = 1;
        period       = 64'($urandom_range(0, 5));
      end
      ack = ($urandom_range(0, 5) == 0);
      tick();
    end
    clr();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
